// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: one-hot grant onto a shared tri-state bus; define ROUND_ROBIN_EN for round-robin, else fixed priority
module tristate_bus_arbiter #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] din,
    input  logic              ready,
    output logic [NCH-1:0]    grant,
    output logic              valid,
    output tri   [DW-1:0]     bus_y
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [NCH-1:0] grant_q, grant_d, win;
    logic own_req, xfer;
    assign own_req = |(req & grant_q);
    assign xfer = (state_q == GRANT) && own_req && ready;
`ifdef ROUND_ROBIN_EN
    localparam int PW = $clog2(NCH);
    logic [PW-1:0] ptr_q, ptr_d, gidx;
    always_comb begin
        gidx = '0;
        for (int k = 0; k < NCH; k++) if (grant_q[k]) gidx = PW'(k);
    end
    // Scan downward from the farthest slot so the first requester at or after the pointer wins.
    always_comb begin
        int j;
        win = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NCH) j = j - NCH;
            if (req[j]) win = NCH'(1) << j;
        end
    end
    assign ptr_d = xfer ? ((int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1) : ptr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win = '0;
        for (int k = NCH - 1; k >= 0; k--) if (req[k]) win = NCH'(1) << k;
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end
    // An abort (owner drops req) and a completed transfer both go back through IDLE.
    always_comb begin
        state_d = (state_q == IDLE) ? (|req ? GRANT : IDLE) : ((xfer || !own_req) ? IDLE : GRANT);
        grant_d = (state_q == IDLE) ? win : ((state_d == IDLE) ? '0 : grant_q);
    end
    always_comb begin
        grant = grant_q;
        valid = |grant_q;
    end
    for (genvar i = 0; i < NCH; i++) begin : g_drv
        assign bus_y = grant_q[i] ? din[i*DW +: DW] : {DW{1'bz}};
    end
endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of source channels, legal range 2..16.
REQ-002 Parameter DW, default 8: data width per channel, legal range 1..64.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NCH  per-channel request; bit i set means channel i holds a word to send.
REQ-006 din  input  NCH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
REQ-007 ready  input  1  sink accepts the bus word this cycle.
REQ-008 grant  output  NCH  registered one-hot grant, or all-zero.
REQ-009 valid  output  1  bus word is valid; equals OR of grant.
REQ-010 bus_y  output  DW  shared bus, driven through one per-channel tri-state buffer enabled by grant[i]; high-Z when grant is zero.

Function
REQ-011 FSM SHALL have two states: IDLE (grant zero) and GRANT (exactly one grant bit set).
REQ-012 In IDLE with req nonzero at edge t, the FSM SHALL set the grant bit of the arbitration winner and enter GRANT; grant is visible after edge t (1-cycle latency).
REQ-013 In IDLE with req zero, the FSM SHALL remain in IDLE.
REQ-014 In GRANT, bus_y SHALL equal din slice of the granted channel combinationally, with no register stage on data.
REQ-015 A transfer SHALL occur on an edge where valid=1, ready=1 and req[granted]=1; the FSM then SHALL return to IDLE with grant cleared.
REQ-016 In GRANT, if req[granted] drops, that is an abort: the FSM SHALL return to IDLE on that edge, and no transfer or pointer update occurs.
REQ-017 In GRANT, ready=0 with req held SHALL hold grant and bus_y unchanged, with no limit on stall length.
REQ-018 Requests from non-granted channels during GRANT SHALL be ignored until the next IDLE cycle; grant never changes channel without passing through IDLE.
REQ-019 Each granted word SHALL cost at least 2 cycles (GRANT plus IDLE); peak throughput is one word per 2 cycles.
REQ-020 At most one grant bit SHALL ever be set; no two buffers drive bus_y simultaneously.
REQ-021 Arbitration winner SHALL be determined per REQ-026/027 from req sampled at the IDLE edge only.

Reset
REQ-022 While rst=1, the block SHALL force grant=0, valid=0 and bus_y=Z, the state to IDLE, and the priority pointer to 0, independent of clk.
REQ-023 Reset asserted in GRANT mid-stall SHALL release the bus immediately; the interrupted word is not counted as transferred.
REQ-024 After rst deasserts, the first arbitration SHALL occur on the first rising edge with req nonzero.

Configuration
REQ-025 Macro ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-026 With ROUND_ROBIN_EN defined, the winner SHALL be the first requesting channel at or above the pointer, searching upward with wrap from NCH-1 to 0; on each transfer the pointer SHALL become (granted+1) mod NCH; an abort leaves the pointer unchanged.
REQ-027 Without ROUND_ROBIN_EN, the winner SHALL be the lowest-index requesting channel (fixed priority); the pointer register SHALL be absent.

Verification
REQ-028 Reset and idle: rst=1 with req=4'b1111 -> grant=0, valid=0, bus_y=ZZ; after release, grant=4'b0001 one cycle later.
REQ-029 Single channel, NCH=4, DW=8: req=4'b0100, din[23:16]=8'hA5, ready=1 -> grant=4'b0100 and bus_y=8'hA5 for one cycle, then IDLE and bus_y=Z.
REQ-030 Round-robin fairness, ROUND_ROBIN_EN defined: req=4'b1111 held, ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with an IDLE cycle between each.
REQ-031 Fixed priority, macro undefined: the same stimulus -> grant=0001 on every grant cycle.
REQ-032 Stall and abort: grant=0010 with ready=0 for 5 cycles -> bus_y stable; then req[1]=0 -> IDLE on the next edge, and the pointer is unchanged, so the next winner with req=4'b0010 is channel 1.
REQ-033 Reset mid-stall: assert rst asynchronously between edges while grant=1000 -> bus_y becomes Z before the next edge.
